cmd_sequencer: RTL and testbench

- Command front-end between UART receiver byte stream and I2C master command/data interface; turns 2- or 3-byte host commands into I2C register writes, single reads or continuous (polled) reads.
- Read bytes go back to the UART transmitter stream.
- Sits directly upstream of the I2C master inside the top-level command block.

---
 rtl/cmd_seq_pkg.sv | 32 +++
 rtl/cmd_seq_timer.sv | 35 +++
 rtl/cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared types for the UART-to-I2C command sequencer: FSM states, command byte field
// positions and the I2C master command word.
package cmd_seq_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StGetReg,
      StGetData,
      StWrPtr,
      StWrData,
      StRdPtr,
      StRdCmd,
      StRdWait,
      StTxOut,
      StPollWait
   } state_e;

   localparam int unsigned ADDR_MSB     = 7;
   localparam int unsigned RW_BIT       = 0;
   localparam int unsigned CONV_BIT     = 7;
   localparam int unsigned REG_MSB      = 6;
   localparam int unsigned MAX_RD_BYTES = 4;

   typedef struct packed {
      logic [6:0] address;
      logic       start;
      logic       read;
      logic       write;
      logic       stop;
   } cmd_t;

endpackage

// File: rtl/cmd_seq_timer.sv
// Loadable down-counter that parks at zero; shared by the inter-byte timeout and the
// conversion poll interval.
module cmd_seq_timer #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_sequencer.sv
// Turns 2/3-byte UART host commands into I2C register writes, single reads and polled
// conversion reads; read bytes are returned on the UART TX stream.
module cmd_sequencer
   import cmd_seq_pkg::*;
#(
   parameter int unsigned RD_BYTES       = 2,
   parameter int unsigned POLL_CYCLES    = 50000,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [6:0] m_axis_cmd_address,
   output logic       m_axis_cmd_start,
   output logic       m_axis_cmd_read,
   output logic       m_axis_cmd_write,
   output logic       m_axis_cmd_stop,
   output logic       m_axis_cmd_valid,
   input  logic       m_axis_cmd_ready,
   output logic [7:0] m_axis_wr_tdata,
   output logic       m_axis_wr_tvalid,
   input  logic       m_axis_wr_tready,
   input  logic [7:0] s_axis_rd_tdata,
   input  logic       s_axis_rd_tvalid,
   output logic       s_axis_rd_tready,
   output logic [7:0] m_axis_tx_tdata,
   output logic       m_axis_tx_tvalid,
   input  logic       m_axis_tx_tready,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [1:0] LastIdx = 2'(RD_BYTES - 1);

   state_e     state_q, state_d;
   logic [6:0] addr_q, addr_d, reg_q, reg_d;
   logic       rw_q, rw_d, conv_q, conv_d;
   logic [7:0] data_q, data_d;
   logic [1:0] rd_idx_q, rd_idx_d, tx_idx_q, tx_idx_d;
   logic [7:0] rd_buf_q [MAX_RD_BYTES];
   logic [7:0] rd_buf_d [MAX_RD_BYTES];
   logic       stop_req_q, stop_req_d;
   logic       cmd_done_q, cmd_done_d, wr_done_q, wr_done_d;
   logic       active_q;
   logic       rd_phase, rx_fire, cmd_ok, wr_ok;
   logic       tmr_load, tmr_en, tmr_zero;
   logic [31:0] tmr_val;
   cmd_t       cmd;

   cmd_seq_timer #(
      .Width(32)
   ) u_timer (
      .clk_i     (clk),
      .rst_ni    (rstn),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .en_i      (tmr_en),
      .zero_o    (tmr_zero)
   );

   // active_q keeps the RX ready low while reset is asserted.
   assign rd_phase = state_q inside {StRdPtr, StRdCmd, StRdWait, StTxOut, StPollWait};
   assign s_axis_tready = active_q &&
                          ((state_q inside {StIdle, StGetReg, StGetData}) || (conv_q && rd_phase));
   assign rx_fire = s_axis_tvalid && s_axis_tready;
   assign busy    = (state_q != StIdle);

   assign m_axis_cmd_address = cmd.address;
   assign m_axis_cmd_start   = cmd.start;
   assign m_axis_cmd_read    = cmd.read;
   assign m_axis_cmd_write   = cmd.write;
   assign m_axis_cmd_stop    = cmd.stop;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      conv_d     = conv_q;
      reg_d      = reg_q;
      data_d     = data_q;
      rd_idx_d   = rd_idx_q;
      tx_idx_d   = tx_idx_q;
      rd_buf_d   = rd_buf_q;
      stop_req_d = stop_req_q;
      cmd_done_d = cmd_done_q;
      wr_done_d  = wr_done_q;
      cmd              = '0;
      m_axis_cmd_valid = 1'b0;
      m_axis_wr_tdata  = '0;
      m_axis_wr_tvalid = 1'b0;
      s_axis_rd_tready = 1'b0;
      m_axis_tx_tdata  = '0;
      m_axis_tx_tvalid = 1'b0;
      timeout_err      = 1'b0;
      tmr_load         = 1'b0;
      tmr_val          = '0;
      tmr_en           = 1'b0;
      // A transfer counts as done if it completed earlier or completes this cycle.
      cmd_ok = cmd_done_q || m_axis_cmd_ready;
      wr_ok  = wr_done_q || m_axis_wr_tready;

      if (rx_fire && rd_phase) stop_req_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (rx_fire) begin
               addr_d     = s_axis_tdata[ADDR_MSB:1];
               rw_d       = s_axis_tdata[RW_BIT];
               stop_req_d = 1'b0;
               tmr_load   = 1'b1;
               tmr_val    = 32'(TIMEOUT_CYCLES - 1);
               state_d    = StGetReg;
            end
         end
         StGetReg, StGetData: begin
            tmr_en = 1'b1;
            if (rx_fire) begin
               tmr_load = 1'b1;
               tmr_val  = 32'(TIMEOUT_CYCLES - 1);
               if (state_q == StGetReg) begin
                  conv_d  = s_axis_tdata[CONV_BIT];
                  reg_d   = s_axis_tdata[REG_MSB:0];
                  state_d = rw_q ? StRdPtr : StGetData;
               end else begin
                  data_d  = s_axis_tdata;
                  state_d = StWrPtr;
               end
            end else if (tmr_zero) begin
               timeout_err = 1'b1;
               state_d     = StIdle;
            end
         end
         StWrPtr, StRdPtr, StWrData: begin
            cmd.address      = addr_q;
            cmd.write        = 1'b1;
            cmd.start        = (state_q != StWrData);
            cmd.stop         = (state_q == StWrData);
            m_axis_cmd_valid = !cmd_done_q;
            m_axis_wr_tdata  = (state_q == StWrData) ? data_q : {1'b0, reg_q};
            m_axis_wr_tvalid = !wr_done_q;
            if (cmd_ok && wr_ok) begin
               cmd_done_d = 1'b0;
               wr_done_d  = 1'b0;
               rd_idx_d   = '0;
               unique case (state_q)
                  StWrPtr: state_d = StWrData;
                  StRdPtr: state_d = StRdCmd;
                  default: state_d = StIdle;
               endcase
            end else begin
               cmd_done_d = cmd_ok;
               wr_done_d  = wr_ok;
            end
         end
         StRdCmd: begin
            cmd.address      = addr_q;
            cmd.start        = (rd_idx_q == '0);
            cmd.read         = 1'b1;
            cmd.stop         = (rd_idx_q == LastIdx);
            m_axis_cmd_valid = 1'b1;
            if (m_axis_cmd_ready) state_d = StRdWait;
         end
         StRdWait: begin
            s_axis_rd_tready = 1'b1;
            if (s_axis_rd_tvalid) begin
               rd_buf_d[rd_idx_q] = s_axis_rd_tdata;
               if (rd_idx_q == LastIdx) begin
                  tx_idx_d = '0;
                  state_d  = StTxOut;
               end else begin
                  rd_idx_d = rd_idx_q + 2'd1;
                  state_d  = StRdCmd;
               end
            end
         end
         StTxOut: begin
            m_axis_tx_tvalid = 1'b1;
            m_axis_tx_tdata  = rd_buf_q[tx_idx_q];
            if (m_axis_tx_tready) begin
               tx_idx_d = tx_idx_q + 2'd1;
               if (tx_idx_q == LastIdx) begin
                  if (conv_q && !(stop_req_q || rx_fire)) begin
                     tmr_load = 1'b1;
                     tmr_val  = 32'(POLL_CYCLES - 1);
                     state_d  = StPollWait;
                  end else begin
                     stop_req_d = 1'b0;
                     state_d    = StIdle;
                  end
               end
            end
         end
         StPollWait: begin
            tmr_en = 1'b1;
            // A stop byte beats an expiring poll interval.
            if (stop_req_q || rx_fire) begin
               stop_req_d = 1'b0;
               state_d    = StIdle;
            end else if (tmr_zero) begin
               state_d = StRdPtr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         conv_q     <= 1'b0;
         reg_q      <= '0;
         data_q     <= '0;
         rd_idx_q   <= '0;
         tx_idx_q   <= '0;
         stop_req_q <= 1'b0;
         cmd_done_q <= 1'b0;
         wr_done_q  <= 1'b0;
         active_q   <= 1'b0;
         for (int unsigned i = 0; i < MAX_RD_BYTES; i++) rd_buf_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         conv_q     <= conv_d;
         reg_q      <= reg_d;
         data_q     <= data_d;
         rd_idx_q   <= rd_idx_d;
         tx_idx_q   <= tx_idx_d;
         stop_req_q <= stop_req_d;
         cmd_done_q <= cmd_done_d;
         wr_done_q  <= wr_done_d;
         active_q   <= 1'b1;
         rd_buf_q   <= rd_buf_d;
      end
   end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: table vectors, directed corner sequences and
// randomized commands compared against a transaction-level model.
module tb_cmd_sequencer;

   localparam int unsigned RDB  = 2;
   localparam int unsigned POLL = 200;
   localparam int unsigned TMO  = 500;

   logic       clk, rstn;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid, s_axis_tready;
   logic [6:0] m_axis_cmd_address;
   logic       m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write, m_axis_cmd_stop;
   logic       m_axis_cmd_valid, m_axis_cmd_ready;
   logic [7:0] m_axis_wr_tdata;
   logic       m_axis_wr_tvalid, m_axis_wr_tready;
   logic [7:0] s_axis_rd_tdata;
   logic       s_axis_rd_tvalid, s_axis_rd_tready;
   logic [7:0] m_axis_tx_tdata;
   logic       m_axis_tx_tvalid, m_axis_tx_tready;
   logic       busy, timeout_err;

   cmd_sequencer #(
      .RD_BYTES      (RDB),
      .POLL_CYCLES   (POLL),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .m_axis_cmd_address(m_axis_cmd_address),
      .m_axis_cmd_start  (m_axis_cmd_start),
      .m_axis_cmd_read   (m_axis_cmd_read),
      .m_axis_cmd_write  (m_axis_cmd_write),
      .m_axis_cmd_stop   (m_axis_cmd_stop),
      .m_axis_cmd_valid  (m_axis_cmd_valid),
      .m_axis_cmd_ready  (m_axis_cmd_ready),
      .m_axis_wr_tdata   (m_axis_wr_tdata),
      .m_axis_wr_tvalid  (m_axis_wr_tvalid),
      .m_axis_wr_tready  (m_axis_wr_tready),
      .s_axis_rd_tdata   (s_axis_rd_tdata),
      .s_axis_rd_tvalid  (s_axis_rd_tvalid),
      .s_axis_rd_tready  (s_axis_rd_tready),
      .m_axis_tx_tdata   (m_axis_tx_tdata),
      .m_axis_tx_tvalid  (m_axis_tx_tvalid),
      .m_axis_tx_tready  (m_axis_tx_tready),
      .busy              (busy),
      .timeout_err       (timeout_err)
   );

   // Command word as {address, start, read, write, stop}; lists packed first-entry-MSB.
   typedef struct {
      logic [7:0]  b0, b1, b2, t0, t1;
      int          ncmd;
      logic [32:0] cmds;
      int          nwr;
      logic [15:0] wrs;
      int          ntx;
      logic [15:0] txs;
   } vec_t;

   int         checks = 0, errors = 0, cyc = 0, tmo_pulses = 0;
   logic       rnd_ready = 1'b0, force_cmd_lo = 1'b0, force_tx_lo = 1'b0;
   logic [10:0] cap_cmd[$];
   logic [7:0]  cap_wr[$], cap_tx[$], tgt_q[$];
   int          ptr_cyc[$];
   vec_t        tbl[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // I2C master / target / UART TX side: readies and read data change just after posedge.
   initial begin
      m_axis_cmd_ready = 1'b0; m_axis_wr_tready = 1'b0; m_axis_tx_tready = 1'b0;
      s_axis_rd_tvalid = 1'b0; s_axis_rd_tdata = '0;
      forever begin
         @(posedge clk); #1;
         m_axis_cmd_ready = force_cmd_lo ? 1'b0 : (rnd_ready ? ($urandom_range(3) != 0) : 1'b1);
         m_axis_wr_tready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
         m_axis_tx_tready = force_tx_lo ? 1'b0 : (rnd_ready ? ($urandom_range(3) != 0) : 1'b1);
         s_axis_rd_tvalid = (tgt_q.size() > 0) && (rnd_ready ? ($urandom_range(1) == 1) : 1'b1);
         s_axis_rd_tdata  = (tgt_q.size() > 0) ? tgt_q[0] : 8'h00;
      end
   end

   // Transfers are sampled at negedge; they complete at the following posedge.
   always @(negedge clk) begin
      if (m_axis_cmd_valid && m_axis_cmd_ready) begin
         cap_cmd.push_back({m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read,
                            m_axis_cmd_write, m_axis_cmd_stop});
         if (m_axis_cmd_start && m_axis_cmd_write) ptr_cyc.push_back(cyc);
      end
      if (m_axis_wr_tvalid && m_axis_wr_tready) cap_wr.push_back(m_axis_wr_tdata);
      if (m_axis_tx_tvalid && m_axis_tx_tready) cap_tx.push_back(m_axis_tx_tdata);
      if (s_axis_rd_tvalid && s_axis_rd_tready && (tgt_q.size() > 0)) void'(tgt_q.pop_front());
      if (timeout_err) tmo_pulses++;
   end

   function automatic logic [63:0] outs();
      return {s_axis_tready, m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read,
              m_axis_cmd_write, m_axis_cmd_stop, m_axis_cmd_valid, m_axis_wr_tdata,
              m_axis_wr_tvalid, s_axis_rd_tready, m_axis_tx_tdata, m_axis_tx_tvalid,
              busy, timeout_err};
   endfunction

   function automatic vec_t model(input logic [7:0] b0, b1, b2, t0, t1);
      vec_t v;
      logic [6:0] a;
      a = b0[7:1];
      v.b0 = b0; v.b1 = b1; v.b2 = b2; v.t0 = t0; v.t1 = t1;
      if (!b0[0]) begin
         v.ncmd = 2; v.cmds = {a, 4'b1010, a, 4'b0011, 11'h0};
         v.nwr = 2;  v.wrs = {1'b0, b1[6:0], b2};
         v.ntx = 0;  v.txs = '0;
      end else begin
         v.ncmd = 3; v.cmds = {a, 4'b1010, a, 4'b1100, a, 4'b0101};
         v.nwr = 1;  v.wrs = {1'b0, b1[6:0], 8'h00};
         v.ntx = 2;  v.txs = {t0, t1};
      end
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic bound_fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   task automatic clear_caps();
      cap_cmd.delete(); cap_wr.delete(); cap_tx.delete(); ptr_cyc.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(posedge clk); #1;
      s_axis_tdata = b; s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && n < 2000) begin @(negedge clk); n++; end
      if (!s_axis_tready) bound_fail("rx_accept");
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_cmd(input vec_t v);
      send_byte(v.b0);
      send_byte(v.b1);
      if (!v.b0[0]) send_byte(v.b2);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      @(negedge clk);
      while (busy && n < 5000) begin @(negedge clk); n++; end
      if (busy) bound_fail({nm, " idle"});
   endtask

   task automatic compare(input string nm, input vec_t e);
      chk({nm, " ncmd"}, 64'(cap_cmd.size()), 64'(e.ncmd));
      for (int i = 0; i < e.ncmd && i < cap_cmd.size(); i++)
         chk($sformatf("%s cmd%0d", nm, i), 64'(cap_cmd[i]), 64'(e.cmds[32-11*i -: 11]));
      chk({nm, " nwr"}, 64'(cap_wr.size()), 64'(e.nwr));
      for (int i = 0; i < e.nwr && i < cap_wr.size(); i++)
         chk($sformatf("%s wr%0d", nm, i), 64'(cap_wr[i]), 64'(e.wrs[15-8*i -: 8]));
      chk({nm, " ntx"}, 64'(cap_tx.size()), 64'(e.ntx));
      for (int i = 0; i < e.ntx && i < cap_tx.size(); i++)
         chk($sformatf("%s tx%0d", nm, i), 64'(cap_tx[i]), 64'(e.txs[15-8*i -: 8]));
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      clear_caps();
      if (v.b0[0]) begin tgt_q.push_back(v.t0); tgt_q.push_back(v.t1); end
      send_cmd(v);
      wait_idle(nm);
      compare(nm, v);
   endtask

   initial begin
      int   n, bad, p0;
      vec_t v;
      logic [7:0] b0, b1;

      tbl[0] = '{b0: 8'h9A, b1: 8'h83, b2: 8'h5C, t0: 8'h00, t1: 8'h00,
                 ncmd: 2, cmds: {7'h4D, 4'b1010, 7'h4D, 4'b0011, 11'h0},
                 nwr: 2, wrs: 16'h035C, ntx: 0, txs: 16'h0};
      tbl[1] = '{b0: 8'h9B, b1: 8'h3B, b2: 8'h00, t0: 8'h12, t1: 8'h34,
                 ncmd: 3, cmds: {7'h4D, 4'b1010, 7'h4D, 4'b1100, 7'h4D, 4'b0101},
                 nwr: 1, wrs: 16'h3B00, ntx: 2, txs: 16'h1234};
      tbl[2] = '{b0: 8'h00, b1: 8'h7F, b2: 8'hFF, t0: 8'h00, t1: 8'h00,
                 ncmd: 2, cmds: {7'h00, 4'b1010, 7'h00, 4'b0011, 11'h0},
                 nwr: 2, wrs: 16'h7FFF, ntx: 0, txs: 16'h0};
      tbl[3] = '{b0: 8'hFF, b1: 8'h00, b2: 8'h00, t0: 8'h00, t1: 8'hFF,
                 ncmd: 3, cmds: {7'h7F, 4'b1010, 7'h7F, 4'b1100, 7'h7F, 4'b0101},
                 nwr: 1, wrs: 16'h0000, ntx: 2, txs: 16'h00FF};

      rstn = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 64'h0);
      @(posedge clk); #1 rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'h0);
      chk("idle_rx_ready", 64'(s_axis_tready), 64'h1);

      for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

      // Inter-byte timeout after a lone first byte.
      clear_caps();
      p0 = tmo_pulses;
      send_byte(8'h9B);
      n = 0;
      @(negedge clk);
      while (!timeout_err && n < 1000) begin @(negedge clk); n++; end
      chk("tmo_latency_in_range", 64'(n >= int'(TMO) - 10 && n <= int'(TMO) + 10), 64'h1);
      @(negedge clk);
      chk("tmo_pulse_width", 64'(timeout_err), 64'h0);
      chk("tmo_back_idle", 64'(busy), 64'h0);
      chk("tmo_pulse_count", 64'(tmo_pulses - p0), 64'h1);
      chk("tmo_no_cmds", 64'(cap_cmd.size()), 64'h0);
      run_vec("after_tmo", tbl[0]);

      // Continuous read: two polled reads, then a stop byte during the poll wait.
      clear_caps();
      tgt_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      send_byte(8'h9B);
      send_byte(8'hBB);
      n = 0;
      while (cap_tx.size() < 4 && n < 2000) begin @(negedge clk); n++; end
      if (cap_tx.size() < 4) bound_fail("conv_tx");
      send_byte(8'h55);
      repeat (3) @(negedge clk);
      chk("conv_stop_idle", 64'(busy), 64'h0);
      repeat (2 * POLL) @(negedge clk);
      chk("conv_ncmd", 64'(cap_cmd.size()), 64'd6);
      chk("conv_ntx", 64'(cap_tx.size()), 64'd4);
      v = model(8'h9B, 8'hBB, 8'h00, 8'hA1, 8'hB2);
      for (int i = 0; i < 6 && i < cap_cmd.size(); i++)
         chk($sformatf("conv cmd%0d", i), 64'(cap_cmd[i]), 64'(v.cmds[32-11*(i%3) -: 11]));
      for (int i = 0; i < 4 && i < cap_tx.size(); i++)
         chk($sformatf("conv tx%0d", i), 64'(cap_tx[i]), 64'(8'hA1 + 8'(i) * 8'h11));
      if (ptr_cyc.size() >= 2)
         chk("conv_interval_in_range", 64'((ptr_cyc[1] - ptr_cyc[0]) >= int'(POLL) &&
             (ptr_cyc[1] - ptr_cyc[0]) <= int'(POLL) + 40), 64'h1);
      else bound_fail("conv_ptr_count");

      // Stop byte during the first read of a conversion: read and TX still complete once.
      clear_caps();
      tgt_q = '{8'h5A, 8'hA5};
      send_byte(8'h9B);
      send_byte(8'hBB);
      send_byte(8'h00);
      wait_idle("stop_mid");
      repeat (POLL + 50) @(negedge clk);
      compare("stop_mid", model(8'h9B, 8'hBB, 8'h00, 8'h5A, 8'hA5));

      // Backpressure on the command channel.
      force_cmd_lo = 1'b1;
      clear_caps();
      send_cmd(tbl[0]);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!(m_axis_cmd_valid && {m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read,
               m_axis_cmd_write, m_axis_cmd_stop} == {7'h4D, 4'b1010})) bad++;
      end
      chk("bp_cmd_held_cycles_bad", 64'(bad), 64'h0);
      chk("bp_cmd_none_taken", 64'(cap_cmd.size()), 64'h0);
      force_cmd_lo = 1'b0;
      wait_idle("bp_cmd");
      compare("bp_cmd", tbl[0]);

      // Backpressure on the UART TX channel.
      force_tx_lo = 1'b1;
      clear_caps();
      tgt_q = '{8'h12, 8'h34};
      send_cmd(tbl[1]);
      n = 0;
      @(negedge clk);
      while (!m_axis_tx_tvalid && n < 500) begin @(negedge clk); n++; end
      if (!m_axis_tx_tvalid) bound_fail("bp_tx_valid");
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!(m_axis_tx_tvalid && m_axis_tx_tdata == 8'h12)) bad++;
      end
      chk("bp_tx_held_cycles_bad", 64'(bad), 64'h0);
      force_tx_lo = 1'b0;
      wait_idle("bp_tx");
      compare("bp_tx", tbl[1]);

      // Reset while waiting for read data.
      clear_caps();
      send_byte(8'h9B);
      send_byte(8'h3B);
      n = 0;
      @(negedge clk);
      while (!s_axis_rd_tready && n < 500) begin @(negedge clk); n++; end
      if (!s_axis_rd_tready) bound_fail("rst_rd_wait");
      rstn = 1'b0;
      #1;
      chk("rst_mid_outputs", outs(), 64'h0);
      @(posedge clk); #1 rstn = 1'b1;
      run_vec("after_rst", tbl[1]);

      // Randomized single commands with random handshakes.
      rnd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         if (b0[0]) b1[7] = 1'b0;
         run_vec($sformatf("rnd%0d", i), model(b0, b1, 8'($urandom), 8'($urandom), 8'($urandom)));
      end
      rnd_ready = 1'b0;
      chk("total_timeout_pulses", 64'(tmo_pulses), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
